mips_cpu_muldiv_unit: RTL and testbench
=======================================

Name: mips_cpu_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
- Driven by the 3-bit mult/div op code produced by the ALU control decoder.
- Generalised to a parametrised operand width with a start/busy/done handshake.
- The CPU stalls on busy; MFHI/MFLO read back through the registered result port.

Parameters:
- WIDTH, 32, operand width in bits; HI/LO are each WIDTH bits wide. Minimum 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  op request; accepted only when busy=0
- op  in  3  op code: 011 MULT, 001 MULTU, 010 DIV, 000 DIVU, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
- a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
- b  in  WIDTH  rt operand (multiplier / divisor)
- busy  out  1  high while a MULT/MULTU/DIV/DIVU is iterating
- done  out  1  single-cycle pulse when any accepted op completes
- result  out  WIDTH  MFHI/MFLO read data; holds until the next MF op completes
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; busy=0, done=0, result=0, hi=0, lo=0; internal accumulators and counter cleared. Reset mid-operation abandons the op, and HI/LO read 0.
- FSM states: IDLE, RUN, FIX, FIN.
- IDLE with start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Latch |a| and |b| (signed ops) or a and b (unsigned ops).
  - Record sign_q = a[W-1]^b[W-1] and sign_r = a[W-1] (signed ops only).
  - Counter := WIDTH, go to RUN; busy=1 from the next cycle.
- RUN, multiply: shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator.
- RUN, divide: restoring, one quotient bit per cycle; remainder is WIDTH+1 bits.
- RUN: counter decrements each cycle; go to FIX when the counter reaches 1.
- FIX:
  - Signed multiply: negate the 2*WIDTH product if sign_q.
  - Signed divide: negate the quotient if sign_q; negate the remainder if sign_r (remainder takes the dividend's sign).
  - Go to FIN.
- FIN:
  - Multiply: {hi,lo} := product.
  - Divide: lo := quotient, hi := remainder.
  - done=1, busy=0; return to IDLE.
- Latency: start accepted at edge 0; done high during the cycle after edge WIDTH+2; HI/LO are valid in that same cycle.
- Divide by zero is not trapped and takes the normal latency. The restoring algorithm gives lo = all ones, hi = a (unsigned). Signed ops apply FIX to those values.
- Signed overflow: DIV of most-negative by -1 gives lo = most-negative, hi = 0 (wraps; no flag).
- MTHI/MTLO (IDLE with start=1): hi := a or lo := a at the next edge; done pulses the following cycle; busy stays 0.
- MFHI/MFLO (IDLE with start=1): result := hi or lo at the next edge; done pulses the following cycle.
- MF immediately after MT: returns the newly written value, because the two ops are sequential through the FSM.
- start while busy=1 is ignored; there is no queue. op, a and b are sampled only on acceptance and may change afterwards.
- start in FIN is ignored. Back-to-back ops therefore need start to be held or reissued in IDLE.
- Unused op values do not exist: all 8 codes are defined.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- With the macro defined, multiply keeps the standard shift order (multiplier shifts right, product accumulates in the upper half) so an all-zero remaining multiplier leaves only shifts.
  - In RUN, if the unconsumed multiplier bits are all zero, the remaining shifts are applied in one cycle and the FSM goes straight to FIX.
  - MULT/MULTU latency becomes (index of highest set bit of |b|)+1+2 cycles; b=0 gives 3 cycles.
  - Divide latency is unchanged.
- Without the macro, every multiply/divide takes exactly WIDTH+2 cycles.
- HI/LO results are identical in both builds.

Test Plan:
- Reset check: reset_n=0 asserted mid-RUN of a MULTU (a=7, b=9) -> hi=lo=0, busy=0, done=0 immediately; after release the FSM is in IDLE.
- MULTU a=32'hFFFF_FFFF, b=32'h0000_0002 -> hi=32'h0000_0001, lo=32'hFFFF_FFFE, done 34 cycles after start (no macro).
- MULT a=-3, b=5 -> {hi,lo} = 64'hFFFF_FFFF_FFFF_FFF1. DIV a=-7, b=2 -> lo=-3 (32'hFFFF_FFFD), hi=-1 (32'hFFFF_FFFF).
- DIVU a=100, b=0 -> lo=32'hFFFF_FFFF, hi=100, normal latency. DIV a=32'h8000_0000, b=-1 -> lo=32'h8000_0000, hi=0.
- MTHI a=32'hDEAD_BEEF, then MFHI -> result=32'hDEAD_BEEF with one done pulse per op. start asserted while busy -> ignored; HI/LO reflect only the first op.
- With MULDIV_EARLY_TERM_EN, MULTU a=1000, b=3 -> lo=3000, hi=0, done 4 cycles after start. Repeat for WIDTH=8: MULTU 8'hFF x 8'hFF -> hi=8'hFE, lo=8'h01.

Source files
------------

// File: rtl/mips_cpu_muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_TERM_EN: multiply finishes early once the remaining multiplier bits are zero.
module mips_cpu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W = WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX, FIN} state_t;

    state_t           state, state_nx;
    logic             accept, last_step, mul_idle;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     mcand;      // multiplicand or divisor magnitude
    logic [W-1:0]     mq;         // multiplier (shifts out) or dividend/quotient
    logic [2*W-1:0]   acc;        // product accumulator
    logic [W:0]       rem;
    logic             sign_q, sign_r, is_div, is_signed;
    logic [W-1:0]     a_abs, b_abs;

    logic [W:0]       add_sum;
    logic [2*W-1:0]   acc_step;
    logic [W:0]       trial;
    logic [W+1:0]     diff;
    logic             qbit;

    assign a_abs = (op[1] && a[W-1]) ? -a : a;
    assign b_abs = (op[1] && b[W-1]) ? -b : b;

    assign add_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (mq[0] ? mcand : {W{1'b0}})};
    assign acc_step = {add_sum, acc[W-1:1]};
    assign trial    = {rem[W-1:0], mq[W-1]};
    assign diff     = {1'b0, trial} - {2'b00, mcand};
    assign qbit     = ~diff[W+1];

`ifdef MULDIV_EARLY_TERM_EN
    assign mul_idle = !is_div && (mq[W-1:1] == '0);
`else
    assign mul_idle = 1'b0;
`endif
    assign last_step = (cnt == CNT_W'(1)) || mul_idle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept = 1'b1;
                if (!op[2]) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_nx = FIX;
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            mcand     <= '0;
            mq        <= '0;
            acc       <= '0;
            rem       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            result    <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == FIN) || (accept && op[2]);
            case (state)
                IDLE: if (accept) begin
                    if (!op[2]) begin
                        is_div    <= ~op[0];
                        is_signed <= op[1];
                        sign_q    <= op[1] & (a[W-1] ^ b[W-1]);
                        sign_r    <= op[1] & a[W-1];
                        mcand     <= op[0] ? a_abs : b_abs;
                        mq        <= op[0] ? b_abs : a_abs;
                        acc       <= '0;
                        rem       <= '0;
                        cnt       <= CNT_W'(W);
                    end else if (!op[1]) begin
                        if (op[0]) lo <= a;
                        else       hi <= a;
                    end else begin
                        result <= op[0] ? lo : hi;
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (is_div) begin
                        rem <= qbit ? diff[W:0] : trial;
                        mq  <= {mq[W-2:0], qbit};
                    end else begin
                        // Remaining shifts carry no adds once the multiplier is exhausted.
                        acc <= mul_idle ? (acc_step >> (cnt - CNT_W'(1))) : acc_step;
                        mq  <= mq >> 1;
                    end
                end
                FIX: if (is_signed) begin
                    if (is_div) begin
                        if (sign_q) mq  <= -mq;
                        if (sign_r) rem <= -rem;
                    end else if (sign_q) begin
                        acc <= -acc;
                    end
                end
                FIN: begin
                    if (is_div) begin
                        lo <= mq;
                        hi <= rem[W-1:0];
                    end else begin
                        {hi, lo} <= acc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// Directed bench for mips_cpu_muldiv_unit: 32-bit vector table plus hand sequences, and an 8-bit instance.
module tb_mips_cpu_muldiv_unit;
    localparam logic [2:0] DIVU = 3'b000, MULTU = 3'b001, DIV = 3'b010, MULT = 3'b011;
    localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, MFHI = 3'b110, MFLO = 3'b111;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] result, hi, lo;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'b000;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [7:0]  result8, hi8, lo8;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mips_cpu_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo));

    mips_cpu_muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .hi(hi8), .lo(lo8));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [31:0] exp_hi, exp_lo;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] y);
        int l;
        logic [31:0] m;
        l = 34;
        m = (o[1] && y[31]) ? -y : y;
`ifdef MULDIV_EARLY_TERM_EN
        if (o[0]) begin
            l = 3;
            for (int i = 0; i < 32; i++) if (m[i]) l = i + 3;
        end
`endif
        return l;
    endfunction

    // Called at #1 after a posedge; start is accepted at the next edge (edge 0).
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic busy1);
        lat   = -1;
        busy1 = 1'b0;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = MTHI;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == 1) busy1 = busy;
            if (done) begin lat = n; break; end
        end
    endtask

    vec_t vecs[12];
    int   lat, lat8, pulses;
    logic busy1;

    initial begin
        vecs[0]  = '{MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[1]  = '{MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[4]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{MULTU, 32'd1000,      32'd3,         32'd0,         32'd3000};
        vecs[6]  = '{MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1};
        vecs[7]  = '{DIVU,  32'd1000,      32'd7,         32'd6,         32'd142};
        vecs[8]  = '{DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9]  = '{MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};
        vecs[10] = '{MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
        vecs[11] = '{MULT,  32'hFFFF_FFFB, 32'd0,         32'd0,         32'd0};

        // Reset state
        #2;
        chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_res", result, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst8_hilo", {hi8, lo8}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy1);
            chk($sformatf("v%0d_lat", i), lat, exp_lat(vecs[i].op, vecs[i].b));
            chk($sformatf("v%0d_busy", i), busy1, 1);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_off", i), {busy, done}, 2'b00);
        end

        // MTHI then MFHI with start held across both
        start = 1'b1; op = MTHI; a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("mthi_done", done, 1); chk("mthi_hi", hi, 32'hDEAD_BEEF); chk("mthi_busy", busy, 0);
        op = MFHI; a = 32'h0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mfhi_done", done, 1); chk("mfhi_res", result, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("mf_done_off", done, 0);

        // MTLO then MFLO
        start = 1'b1; op = MTLO; a = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h1234_5678); chk("mtlo_hi_kept", hi, 32'hDEAD_BEEF);
        start = 1'b1; op = MFLO;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mflo_res", result, 32'h1234_5678);

        // start while busy is ignored
        start = 1'b1; op = MULTU; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk); #1;
        start = 1'b1; op = DIVU; a = 32'd99; b = 32'd7;
        @(posedge clk); #1;
        op = MTHI; a = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_held", busy, 1);
        pulses = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("busy_pulses", pulses, 1);
        chk("busy_hi", hi, 0); chk("busy_lo", lo, 30);

        // Asynchronous reset mid-RUN of MULTU 7*9
        start = 1'b1; op = MULTU; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_hilo", {hi, lo}, 0); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0); chk("mid_rst_res", result, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        start = 1'b1; op = MTLO; a = 32'h0000_0055;
        @(posedge clk); #1;
        start = 1'b0;
        chk("post_rst_idle", {busy, done, lo}, {1'b0, 1'b1, 32'h0000_0055});

        // 8-bit instance
        start8 = 1'b1; op8 = MULTU; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat8 = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); #1;
            if (done8) begin lat8 = n; break; end
        end
        chk("w8_lat", lat8, 10);
        chk("w8_hi", hi8, 8'hFE); chk("w8_lo", lo8, 8'h01);

        start8 = 1'b1; op8 = DIV; a8 = 8'h80; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat8 = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); #1;
            if (done8) begin lat8 = n; break; end
        end
        chk("w8_div_lat", lat8, 10);
        chk("w8_div_hilo", {hi8, lo8}, 16'h0080);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
